// File: rtl/bus_timer_pkg.sv
// -----------------------------------------------------------------------------
// bus_timer_pkg
// Shared definitions for the bus timer responder: register offsets inside the
// 32-byte window, CTRL/STATUS bit positions, the bus FSM state encoding and the
// BUS_mode encodings.
// -----------------------------------------------------------------------------
package bus_timer_pkg;

  // Byte offsets of the registers inside the window
  localparam logic [4:0] CTRL_OFS     = 5'h00;
  localparam logic [4:0] PRESCALE_OFS = 5'h04;
  localparam logic [4:0] COUNT_OFS    = 5'h08;
  localparam logic [4:0] COMPARE_OFS  = 5'h0C;
  localparam logic [4:0] STATUS_OFS   = 5'h10;
  localparam logic [4:0] CAPTURE_OFS  = 5'h14;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AR_BIT     = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // STATUS bit positions
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_CAP_BIT   = 1;

  // BUS_mode encodings
  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  // Bus responder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WACK  = 2'd1,
    RDATA = 2'd2,
    DROP  = 2'd3
  } bus_state_e;

  // Word-aligned byte offset from the register index bits; byte lanes ignored
  function automatic logic [4:0] reg_offset(input logic [2:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/bus_timer_slave_timer_core.sv
// -----------------------------------------------------------------------------
// timer_core
// Prescaled 32-bit up-counter with compare match, auto-reload and the sticky
// MATCH flag. With TIMER_CAPTURE_EN defined it also synchronises cap_in and
// latches COUNT into CAPTURE on a rising edge, setting the sticky CAP flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en, auto_reload CTRL.EN and CTRL.AUTO_RELOAD
//   prescale        PRESCALE register value
//   prescale_wr     PRESCALE is being written this cycle (clears prescaler)
//   count_wr, wdata bus write of COUNT (wins over a tick)
//   compare         COMPARE register value
//   status_clr      write-1-to-clear mask for STATUS[1:0]
//   cap_in          asynchronous capture input (TIMER_CAPTURE_EN only)
//   count, match    COUNT register and STATUS.MATCH
//   cap, capture    STATUS.CAP and CAPTURE (constant 0 without the feature)
// -----------------------------------------------------------------------------
module timer_core
  import bus_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  prescale_wr,
  input  logic                  count_wr,
  input  logic [31:0]           wdata,
  input  logic [31:0]           compare,
  input  logic [1:0]            status_clr,
`ifdef TIMER_CAPTURE_EN
  input  logic                  cap_in,
`endif
  output logic [31:0]           count,
  output logic                  match,
  output logic                  cap,
  output logic [31:0]           capture
);

  logic [PRESCALE_W-1:0] psc_r;
  logic                  tick_s;
  logic [31:0]           count_r;
  logic [31:0]           count_nxt_s;
  logic                  match_r;
  logic                  match_set_s;

  // A tick fires on the cycle the prescaler reaches PRESCALE
  assign tick_s      = en && (psc_r == prescale);
  assign match_set_s = tick_s && (count_r == compare);

  // Prescaler: restarts on a PRESCALE write, otherwise counts only while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_r <= '0;
    end else if (prescale_wr) begin
      psc_r <= '0;
    end else if (tick_s) begin
      psc_r <= '0;
    end else if (en) begin
      psc_r <= psc_r + PRESCALE_W'(1);
    end else begin
      psc_r <= psc_r;
    end
  end

  // Next COUNT: a bus write overrides the tick; a match reloads when enabled
  always_comb begin
    count_nxt_s = count_r;
    if (count_wr) begin
      count_nxt_s = wdata;
    end else if (tick_s) begin
      if (match_set_s && auto_reload) begin
        count_nxt_s = 32'h0000_0000;
      end else begin
        count_nxt_s = count_r + 32'h0000_0001;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // COUNT and sticky MATCH; a new match beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 32'h0000_0000;
      match_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      match_r <= match_set_s | (match_r & ~status_clr[STATUS_MATCH_BIT]);
    end
  end

  assign count = count_r;
  assign match = match_r;

`ifdef TIMER_CAPTURE_EN
  logic [2:0]  cap_sync_r;
  logic        cap_rise_s;
  logic        cap_r;
  logic [31:0] capture_r;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_sync_r <= 3'b000;
    end else begin
      cap_sync_r <= {cap_sync_r[1:0], cap_in};
    end
  end

  assign cap_rise_s = cap_sync_r[1] & ~cap_sync_r[2];

  // CAPTURE latch and sticky CAP flag; a new edge beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capture_r <= 32'h0000_0000;
      cap_r     <= 1'b0;
    end else begin
      if (cap_rise_s) begin
        capture_r <= count_r;
      end else begin
        capture_r <= capture_r;
      end
      cap_r <= cap_rise_s | (cap_r & ~status_clr[STATUS_CAP_BIT]);
    end
  end

  assign cap     = cap_r;
  assign capture = capture_r;
`else
  logic clr_unused_s;

  assign clr_unused_s = status_clr[STATUS_CAP_BIT];
  assign cap          = 1'b0;
  assign capture      = 32'h0000_0000;
`endif

endmodule

// File: rtl/bus_timer_slave.sv
// -----------------------------------------------------------------------------
// bus_timer_slave
// Timer peripheral responding on the shared BUS_* interface. Decodes a 32-byte
// window at BASE_ADDR, holds CTRL/PRESCALE/COMPARE, hands COUNT/STATUS to
// timer_core, and runs the IDLE/WACK/RDATA/DROP responder FSM. Optional
// capture support is compiled in with the TIMER_CAPTURE_EN macro.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   BUS_addr     byte address; [31:5] selects the window, [4:2] the register
//   BUS_wdata    write data
//   BUS_mode     1 = write, 0 = read
//   BUS_valid    request valid, held until the transfer completes
//   BUS_rready   initiator ready for read data
//   cap_in       capture input (TIMER_CAPTURE_EN only)
//   BUS_wready   one-cycle write acknowledge
//   BUS_rvalid   read data valid, held until BUS_rready
//   BUS_rdata    read data, zero whenever BUS_rvalid is low
//   irq          registered level interrupt
// -----------------------------------------------------------------------------
module bus_timer_slave
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  input  logic        BUS_rready,
`ifdef TIMER_CAPTURE_EN
  input  logic        cap_in,
`endif
  output logic        BUS_wready,
  output logic        BUS_rvalid,
  output logic [31:0] BUS_rdata,
  output logic        irq
);

  logic                  sel_s;
  logic [4:0]            ofs_s;
  logic                  addr_unused_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  bus_state_e            state_r;
  bus_state_e            state_nxt_s;

  logic [2:0]            ctrl_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [31:0]           compare_r;

  logic                  prescale_wr_s;
  logic                  count_wr_s;
  logic [1:0]            status_clr_s;
  logic [31:0]           count_s;
  logic [31:0]           capture_s;
  logic                  match_s;
  logic                  cap_s;

  logic [31:0]           rd_mux_s;
  logic [31:0]           rdata_nxt_s;
  logic [31:0]           rdata_r;
  logic                  wready_r;
  logic                  rvalid_r;
  logic                  irq_r;

  assign sel_s         = BUS_valid && (BUS_addr[31:5] == BASE_ADDR[31:5]);
  assign ofs_s         = reg_offset(BUS_addr[4:2]);
  assign addr_unused_s = ^BUS_addr[1:0];

  // Requests are only accepted from IDLE, so a held request is taken once
  assign wr_en_s = (state_r == IDLE) && sel_s && (BUS_mode == MODE_WRITE);
  assign rd_en_s = (state_r == IDLE) && sel_s && (BUS_mode == MODE_READ);

  assign prescale_wr_s = wr_en_s && (ofs_s == PRESCALE_OFS);
  assign count_wr_s    = wr_en_s && (ofs_s == COUNT_OFS);
  assign status_clr_s  = (wr_en_s && (ofs_s == STATUS_OFS)) ? BUS_wdata[1:0] : 2'b00;

  // Configuration registers commit on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r     <= 3'b000;
      prescale_r <= '0;
      compare_r  <= 32'h0000_0000;
    end else if (wr_en_s) begin
      case (ofs_s)
        CTRL_OFS:     ctrl_r     <= BUS_wdata[2:0];
        PRESCALE_OFS: prescale_r <= BUS_wdata[PRESCALE_W-1:0];
        COMPARE_OFS:  compare_r  <= BUS_wdata;
        default:      ;
      endcase
    end
  end

  timer_core #(
    .PRESCALE_W (PRESCALE_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .en          (ctrl_r[CTRL_EN_BIT]),
    .auto_reload (ctrl_r[CTRL_AR_BIT]),
    .prescale    (prescale_r),
    .prescale_wr (prescale_wr_s),
    .count_wr    (count_wr_s),
    .wdata       (BUS_wdata),
    .compare     (compare_r),
    .status_clr  (status_clr_s),
`ifdef TIMER_CAPTURE_EN
    .cap_in      (cap_in),
`endif
    .count       (count_s),
    .match       (match_s),
    .cap         (cap_s),
    .capture     (capture_s)
  );

  // Read multiplexer; unused offsets and unimplemented bits read as zero
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (ofs_s)
      CTRL_OFS:     rd_mux_s[2:0]            = ctrl_r;
      PRESCALE_OFS: rd_mux_s[PRESCALE_W-1:0] = prescale_r;
      COUNT_OFS:    rd_mux_s                 = count_s;
      COMPARE_OFS:  rd_mux_s                 = compare_r;
      STATUS_OFS: begin
        rd_mux_s[STATUS_MATCH_BIT] = match_s;
        rd_mux_s[STATUS_CAP_BIT]   = cap_s;
      end
      CAPTURE_OFS:  rd_mux_s                 = capture_s;
      default:      rd_mux_s                 = 32'h0000_0000;
    endcase
  end

  // Bus FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_s) begin
          state_nxt_s = (BUS_mode == MODE_WRITE) ? WACK : RDATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WACK: state_nxt_s = DROP;
      RDATA: begin
        if (BUS_rready) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = RDATA;
        end
      end
      DROP: begin
        if (!BUS_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read data snapshot: loaded at acceptance, held through RDATA, zero otherwise
  always_comb begin
    rdata_nxt_s = 32'h0000_0000;
    if (rd_en_s) begin
      rdata_nxt_s = rd_mux_s;
    end else if ((state_r == RDATA) && !BUS_rready) begin
      rdata_nxt_s = rdata_r;
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end
  end

  // Registered bus responses and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wready_r <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      irq_r    <= 1'b0;
    end else begin
      wready_r <= (state_nxt_s == WACK);
      rvalid_r <= (state_nxt_s == RDATA);
      rdata_r  <= rdata_nxt_s;
      irq_r    <= (match_s | cap_s) & ctrl_r[CTRL_IRQ_EN_BIT];
    end
  end

  assign BUS_wready = wready_r;
  assign BUS_rvalid = rvalid_r;
  assign BUS_rdata  = rdata_r;
  assign irq        = irq_r;

endmodule
